// File: rtl/axi4_burst_master.sv
// Command-driven AXI4 burst master: one command per cycle into AW/AR pending slots,
// W beats framed by a length FIFO, R passed straight through, response errors latched.
module axi4_burst_master #(
    parameter int ADDR_WIDTH        = 32,
    parameter int DATA_WIDTH        = 128,
    parameter int MAX_OUTSTANDING_W = 4,
    parameter int MAX_OUTSTANDING_R = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [7:0]                cmd_len,
    input  logic [1:0]                cmd_burst,
    input  logic                      cmd_rw,
    output logic                      cmd_err,
    input  logic                      s_wvalid,
    output logic                      s_wready,
    input  logic [DATA_WIDTH-1:0]     s_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_wstrb,
    output logic                      awvalid,
    input  logic                      awready,
    output logic [ADDR_WIDTH-1:0]     awaddr,
    output logic [7:0]                awlen,
    output logic [2:0]                awsize,
    output logic [1:0]                awburst,
    output logic                      wvalid,
    input  logic                      wready,
    output logic [DATA_WIDTH-1:0]     wdata,
    output logic [DATA_WIDTH/8-1:0]   wstrb,
    output logic                      wlast,
    input  logic                      bvalid,
    output logic                      bready,
    input  logic [1:0]                bresp,
    output logic                      arvalid,
    input  logic                      arready,
    output logic [ADDR_WIDTH-1:0]     araddr,
    output logic [7:0]                arlen,
    output logic [2:0]                arsize,
    output logic [1:0]                arburst,
    input  logic                      rvalid,
    output logic                      rready,
    input  logic [DATA_WIDTH-1:0]     rdata,
    input  logic [1:0]                rresp,
    input  logic                      rlast,
    output logic                      m_rvalid,
    input  logic                      m_rready,
    output logic [DATA_WIDTH-1:0]     m_rdata,
    output logic [1:0]                m_rresp,
    output logic                      m_rlast,
    input  logic                      err_clr,
    output logic                      err_sticky,
    output logic                      busy
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int SIZE  = $clog2(BYTES);
    localparam int WCW   = $clog2(MAX_OUTSTANDING_W + 1);
    localparam int RCW   = $clog2(MAX_OUTSTANDING_R + 1);
    localparam int FPW   = (MAX_OUTSTANDING_W > 1) ? $clog2(MAX_OUTSTANDING_W) : 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
        ~((ADDR_WIDTH'(1) << SIZE) - ADDR_WIDTH'(1));

    // FIXED/WRAP lengths and the INCR 4KB boundary are judged on the raw command address.
    function automatic logic cmd_illegal(input logic [11:0] addr_lo,
                                         input logic [7:0]  len,
                                         input logic [1:0]  burst);
        logic [31:0] end_v;
        logic        ill_v;
        end_v = {20'd0, addr_lo} + (({24'd0, len} + 32'd1) << SIZE);
        case (burst)
            2'b00:   ill_v = (len > 8'd15);
            2'b01:   ill_v = (end_v > 32'd4096);
            2'b10:   ill_v = !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
            default: ill_v = 1'b1;
        endcase
        return ill_v;
    endfunction

    function automatic logic [FPW-1:0] ptr_next(input logic [FPW-1:0] p);
        logic [FPW-1:0] n_v;
        if (p == FPW'(MAX_OUTSTANDING_W - 1)) begin
            n_v = {FPW{1'b0}};
        end else begin
            n_v = p + FPW'(1);
        end
        return n_v;
    endfunction

    logic                  aw_pend_r;
    logic [ADDR_WIDTH-1:0] aw_addr_r;
    logic [7:0]            aw_len_r;
    logic [1:0]            aw_burst_r;
    logic                  ar_pend_r;
    logic [ADDR_WIDTH-1:0] ar_addr_r;
    logic [7:0]            ar_len_r;
    logic [1:0]            ar_burst_r;
    logic [WCW-1:0]        w_cnt_r;
    logic [RCW-1:0]        r_cnt_r;
    logic [7:0]            fifo_mem_r [MAX_OUTSTANDING_W];
    logic [FPW-1:0]        fifo_wr_ptr_r;
    logic [FPW-1:0]        fifo_rd_ptr_r;
    logic [WCW-1:0]        fifo_cnt_r;
    logic [7:0]            beat_cnt_r;
    logic                  cmd_err_r;
    logic                  err_sticky_r;
    logic                  bready_r;

    logic wr_ok_s, rd_ok_s, cmd_acc_s, ill_s, wr_acc_s, rd_acc_s;
    logic fifo_nempty_s, w_hs_s, w_pop_s, b_hs_s, r_hs_s, r_done_s, err_set_s;
    logic [7:0] fifo_head_s;

    // A direction can take a command when its address slot drains this cycle and limits allow.
    assign wr_ok_s   = (!aw_pend_r || awready) && (w_cnt_r < WCW'(MAX_OUTSTANDING_W))
                       && (fifo_cnt_r < WCW'(MAX_OUTSTANDING_W));
    assign rd_ok_s   = (!ar_pend_r || arready) && (r_cnt_r < RCW'(MAX_OUTSTANDING_R));
    assign cmd_ready = cmd_rw ? rd_ok_s : wr_ok_s;
    assign cmd_acc_s = cmd_valid && cmd_ready;
    assign ill_s     = cmd_illegal(cmd_addr[11:0], cmd_len, cmd_burst);
    assign wr_acc_s  = cmd_acc_s && !cmd_rw && !ill_s;
    assign rd_acc_s  = cmd_acc_s && cmd_rw && !ill_s;

    assign fifo_nempty_s = (fifo_cnt_r != WCW'(0));
    assign fifo_head_s   = fifo_mem_r[fifo_rd_ptr_r];
    assign wvalid        = s_wvalid && fifo_nempty_s;
    assign s_wready      = wready && fifo_nempty_s;
    assign wdata         = s_wdata;
    assign wstrb         = s_wstrb;
    assign wlast         = (beat_cnt_r == fifo_head_s);
    assign w_hs_s        = wvalid && wready;
    assign w_pop_s       = w_hs_s && wlast;

    assign b_hs_s    = bvalid && bready_r;
    assign r_hs_s    = rvalid && m_rready;
    assign r_done_s  = r_hs_s && rlast;
    assign err_set_s = (b_hs_s && (bresp != 2'b00)) || (r_hs_s && (rresp != 2'b00));

    assign awvalid = aw_pend_r;
    assign awaddr  = aw_addr_r;
    assign awlen   = aw_len_r;
    assign awsize  = 3'(SIZE);
    assign awburst = aw_burst_r;
    assign arvalid = ar_pend_r;
    assign araddr  = ar_addr_r;
    assign arlen   = ar_len_r;
    assign arsize  = 3'(SIZE);
    assign arburst = ar_burst_r;
    assign bready  = bready_r;

    assign m_rvalid = rvalid;
    assign rready   = m_rready;
    assign m_rdata  = rdata;
    assign m_rresp  = rresp;
    assign m_rlast  = rlast;

    assign cmd_err    = cmd_err_r;
    assign err_sticky = err_sticky_r;
    assign busy       = aw_pend_r || ar_pend_r || (w_cnt_r != WCW'(0))
                        || (r_cnt_r != RCW'(0)) || fifo_nempty_s;

    // AW pending slot: load on legal write accept, release on address handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_pend_r  <= 1'b0;
            aw_addr_r  <= {ADDR_WIDTH{1'b0}};
            aw_len_r   <= 8'd0;
            aw_burst_r <= 2'b00;
        end else if (wr_acc_s) begin
            aw_pend_r  <= 1'b1;
            aw_addr_r  <= cmd_addr & ALIGN_MASK;
            aw_len_r   <= cmd_len;
            aw_burst_r <= cmd_burst;
        end else if (aw_pend_r && awready) begin
            aw_pend_r  <= 1'b0;
        end else begin
            aw_pend_r  <= aw_pend_r;
        end
    end

    // AR pending slot: load on legal read accept, release on address handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar_pend_r  <= 1'b0;
            ar_addr_r  <= {ADDR_WIDTH{1'b0}};
            ar_len_r   <= 8'd0;
            ar_burst_r <= 2'b00;
        end else if (rd_acc_s) begin
            ar_pend_r  <= 1'b1;
            ar_addr_r  <= cmd_addr & ALIGN_MASK;
            ar_len_r   <= cmd_len;
            ar_burst_r <= cmd_burst;
        end else if (ar_pend_r && arready) begin
            ar_pend_r  <= 1'b0;
        end else begin
            ar_pend_r  <= ar_pend_r;
        end
    end

    // Outstanding write bursts: accepted but not yet answered on B.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_cnt_r <= WCW'(0);
        end else begin
            case ({wr_acc_s, b_hs_s && (w_cnt_r != WCW'(0))})
                2'b10:   w_cnt_r <= w_cnt_r + WCW'(1);
                2'b01:   w_cnt_r <= w_cnt_r - WCW'(1);
                default: w_cnt_r <= w_cnt_r;
            endcase
        end
    end

    // Outstanding read bursts: accepted but last R beat not yet delivered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_r <= RCW'(0);
        end else begin
            case ({rd_acc_s, r_done_s && (r_cnt_r != RCW'(0))})
                2'b10:   r_cnt_r <= r_cnt_r + RCW'(1);
                2'b01:   r_cnt_r <= r_cnt_r - RCW'(1);
                default: r_cnt_r <= r_cnt_r;
            endcase
        end
    end

    // W-length FIFO: one entry per legal write, popped on each wlast handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_OUTSTANDING_W; i++) begin
                fifo_mem_r[i] <= 8'd0;
            end
            fifo_wr_ptr_r <= {FPW{1'b0}};
            fifo_rd_ptr_r <= {FPW{1'b0}};
            fifo_cnt_r    <= WCW'(0);
        end else begin
            if (wr_acc_s) begin
                fifo_mem_r[fifo_wr_ptr_r] <= cmd_len;
                fifo_wr_ptr_r             <= ptr_next(fifo_wr_ptr_r);
            end else begin
                fifo_wr_ptr_r <= fifo_wr_ptr_r;
            end
            if (w_pop_s) begin
                fifo_rd_ptr_r <= ptr_next(fifo_rd_ptr_r);
            end else begin
                fifo_rd_ptr_r <= fifo_rd_ptr_r;
            end
            case ({wr_acc_s, w_pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + WCW'(1);
                2'b01:   fifo_cnt_r <= fifo_cnt_r - WCW'(1);
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    // Beat position within the current W burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_r <= 8'd0;
        end else if (w_pop_s) begin
            beat_cnt_r <= 8'd0;
        end else if (w_hs_s) begin
            beat_cnt_r <= beat_cnt_r + 8'd1;
        end else begin
            beat_cnt_r <= beat_cnt_r;
        end
    end

    // Illegal-command pulse, sticky response error (set beats clear), B always ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_err_r    <= 1'b0;
            err_sticky_r <= 1'b0;
            bready_r     <= 1'b0;
        end else begin
            cmd_err_r <= cmd_acc_s && ill_s;
            bready_r  <= 1'b1;
            if (err_set_s) begin
                err_sticky_r <= 1'b1;
            end else if (err_clr) begin
                err_sticky_r <= 1'b0;
            end else begin
                err_sticky_r <= err_sticky_r;
            end
        end
    end

endmodule

// File: tb/tb_axi4_burst_master.sv
// Directed + randomized bench for axi4_burst_master against a transaction-level model.
module tb_axi4_burst_master;

    localparam int AW    = 32;
    localparam int DW    = 128;
    localparam int BYTES = DW / 8;

    logic            clk, rst_n;
    logic            cmd_valid, cmd_ready, cmd_rw, cmd_err;
    logic [AW-1:0]   cmd_addr;
    logic [7:0]      cmd_len;
    logic [1:0]      cmd_burst;
    logic            s_wvalid, s_wready;
    logic [DW-1:0]   s_wdata;
    logic [BYTES-1:0] s_wstrb;
    logic            awvalid, awready;
    logic [AW-1:0]   awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic            wvalid, wready, wlast;
    logic [DW-1:0]   wdata;
    logic [BYTES-1:0] wstrb;
    logic            bvalid, bready;
    logic [1:0]      bresp;
    logic            arvalid, arready;
    logic [AW-1:0]   araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic            rvalid, rready, rlast;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            m_rvalid, m_rready, m_rlast;
    logic [DW-1:0]   m_rdata;
    logic [1:0]      m_rresp;
    logic            err_clr, err_sticky, busy;

    int n_chk  = 0;
    int n_fail = 0;
    bit exp_err = 1'b0;

    axi4_burst_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING_W(4), .MAX_OUTSTANDING_R(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_burst(cmd_burst), .cmd_rw(cmd_rw), .cmd_err(cmd_err),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_rlast(m_rlast),
        .err_clr(err_clr), .err_sticky(err_sticky), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed no end of test, expected finish before 5 ms");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Legality straight from the command rules, in plain integer arithmetic.
    function automatic bit legal_cmd(input logic [31:0] a, input int len, input logic [1:0] b);
        case (b)
            2'b00:   return (len <= 15);
            2'b01:   return (int'(a % 32'd4096) + (len + 1) * BYTES) <= 4096;
            2'b10:   return (len == 1) || (len == 3) || (len == 7) || (len == 15);
            default: return 1'b0;
        endcase
    endfunction

    task automatic send_cmd(input logic rw, input logic [31:0] a, input int len, input logic [1:0] b);
        cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = a; cmd_len = 8'(len); cmd_burst = b;
        #1;
        chk("cmd_ready", cmd_ready, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input int len, input logic [1:0] b,
                            input int d, input logic [1:0] bresp_v, input bit clr_with_b);
        bit legal;
        legal   = legal_cmd(a, len, b);
        awready = (d == 0);
        send_cmd(1'b0, a, len, b);
        if (!legal) begin
            chk("cmd_err_pulse", cmd_err, 1'b1);
            chk("awvalid_illegal", awvalid, 1'b0);
            chk("arvalid_illegal", arvalid, 1'b0);
            chk("busy_illegal", busy, 1'b0);
            @(posedge clk); #1;
            chk("cmd_err_drop", cmd_err, 1'b0);
            awready = 1'b1;
        end else begin
            chk("cmd_err_legal_w", cmd_err, 1'b0);
            chk("busy_w", busy, 1'b1);
            chk("awvalid", awvalid, 1'b1);
            chk("awaddr", awaddr, a & 32'hFFFF_FFF0);
            chk("awlen", awlen, 8'(len));
            chk("awsize", awsize, 3'd4);
            chk("awburst", awburst, b);
            for (int k = 0; k < d; k++) begin
                @(posedge clk); #1;
                chk("awvalid_hold", awvalid, 1'b1);
                chk("awaddr_hold", awaddr, a & 32'hFFFF_FFF0);
            end
            awready = 1'b1;
            @(posedge clk); #1;
            chk("awvalid_done", awvalid, 1'b0);
            for (int i = 0; i <= len; i++) begin
                s_wvalid = 1'b1;
                s_wdata  = {$urandom, $urandom, $urandom, $urandom};
                s_wstrb  = 16'($urandom);
                #1;
                chk("wvalid", wvalid, 1'b1);
                chk("s_wready", s_wready, 1'b1);
                chk("wlast", wlast, (i == len));
                chk("wdata", wdata, s_wdata);
                chk("wstrb", wstrb, s_wstrb);
                @(posedge clk); #1;
            end
            s_wvalid = 1'b0;
            #1;
            chk("wvalid_idle", wvalid, 1'b0);
            bvalid = 1'b1; bresp = bresp_v; err_clr = clr_with_b;
            #1;
            chk("bready", bready, 1'b1);
            @(posedge clk); #1;
            bvalid = 1'b0; err_clr = 1'b0;
            if (bresp_v != 2'b00) exp_err = 1'b1;
            else if (clr_with_b)  exp_err = 1'b0;
            #1;
            chk("busy_w_done", busy, 1'b0);
            chk("err_sticky_w", err_sticky, exp_err);
        end
    endtask

    task automatic do_read(input logic [31:0] a, input int len, input logic [1:0] b,
                           input int d, input int bad_beat);
        bit legal;
        logic [1:0] resp;
        legal   = legal_cmd(a, len, b);
        arready = (d == 0);
        send_cmd(1'b1, a, len, b);
        if (!legal) begin
            chk("cmd_err_pulse_r", cmd_err, 1'b1);
            chk("arvalid_illegal", arvalid, 1'b0);
            chk("awvalid_illegal_r", awvalid, 1'b0);
            chk("busy_illegal_r", busy, 1'b0);
            @(posedge clk); #1;
            chk("cmd_err_drop_r", cmd_err, 1'b0);
            arready = 1'b1;
        end else begin
            chk("busy_r", busy, 1'b1);
            chk("arvalid", arvalid, 1'b1);
            chk("araddr", araddr, a & 32'hFFFF_FFF0);
            chk("arlen", arlen, 8'(len));
            chk("arsize", arsize, 3'd4);
            chk("arburst", arburst, b);
            for (int k = 0; k < d; k++) begin
                @(posedge clk); #1;
                chk("arvalid_hold", arvalid, 1'b1);
                chk("araddr_hold", araddr, a & 32'hFFFF_FFF0);
            end
            arready = 1'b1;
            @(posedge clk); #1;
            chk("arvalid_done", arvalid, 1'b0);
            for (int i = 0; i <= len; i++) begin
                resp   = (i == bad_beat) ? 2'b10 : 2'b00;
                rvalid = 1'b1; rlast = (i == len); rresp = resp;
                rdata  = {$urandom, $urandom, $urandom, $urandom};
                if ($urandom_range(0, 3) == 0) begin
                    m_rready = 1'b0;
                    #1;
                    chk("rready_stall", rready, 1'b0);
                    @(posedge clk); #1;
                    m_rready = 1'b1;
                end
                #1;
                chk("m_rvalid", m_rvalid, 1'b1);
                chk("rready", rready, 1'b1);
                chk("m_rdata", m_rdata, rdata);
                chk("m_rresp", m_rresp, resp);
                chk("m_rlast", m_rlast, (i == len));
                chk("err_sticky_r_beat", err_sticky, exp_err);
                @(posedge clk); #1;
                if (resp != 2'b00) exp_err = 1'b1;
            end
            rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
            #1;
            chk("busy_r_done", busy, 1'b0);
            chk("err_sticky_r", err_sticky, exp_err);
        end
    endtask

    initial begin
        int lens [7] = '{0, 1, 3, 5, 7, 15, 16};
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_len = 8'd0;
        cmd_burst = 2'b00; s_wvalid = 1'b0; s_wdata = '0; s_wstrb = '0;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b0; bresp = 2'b00; arready = 1'b1;
        rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; m_rready = 1'b1;
        err_clr = 1'b0;
        #3;
        chk("rst_awvalid", awvalid, 1'b0);
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_wvalid", wvalid, 1'b0);
        chk("rst_cmd_err", cmd_err, 1'b0);
        chk("rst_err_sticky", err_sticky, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_bready", bready, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("bready_after_rst", bready, 1'b1);

        // 1: INCR write, 8 beats
        do_write(32'h0000_1000, 7, 2'b01, 0, 2'b00, 1'b0);
        // 2: WRAP read from unaligned address
        do_read(32'h0000_2034, 3, 2'b10, 0, -1);

        // 3: write outstanding limit
        for (int i = 0; i < 4; i++) send_cmd(1'b0, 32'h0000_4000 + 32'(i) * 32'h100, 0, 2'b01);
        cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 32'h0000_4400; cmd_len = 8'd0; cmd_burst = 2'b01;
        #1;
        chk("limit_ready_0", cmd_ready, 1'b0);
        for (int i = 0; i < 4; i++) begin
            s_wvalid = 1'b1; s_wdata = {4{$urandom}};
            #1;
            chk("limit_wlast", wlast, 1'b1);
            @(posedge clk); #1;
        end
        s_wvalid = 1'b0;
        #1;
        chk("limit_ready_fifo_empty", cmd_ready, 1'b0);
        bvalid = 1'b1; bresp = 2'b00;
        @(posedge clk); #1;
        bvalid = 1'b0;
        #1;
        chk("limit_ready_1", cmd_ready, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("limit_5th_aw", awvalid, 1'b1);
        chk("limit_5th_awaddr", awaddr, 32'h0000_4400);
        s_wvalid = 1'b1;
        @(posedge clk); #1;
        s_wvalid = 1'b0;
        bvalid = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        bvalid = 1'b0;
        #1;
        chk("limit_busy_done", busy, 1'b0);

        // 4: illegal commands
        do_write(32'h0000_8000, 5, 2'b10, 0, 2'b00, 1'b0);
        do_read(32'h0000_0FF0, 1, 2'b01, 0, -1);
        do_write(32'h0000_9000, 0, 2'b11, 0, 2'b00, 1'b0);

        // 5: sticky error, clear, and set-wins-over-clear
        do_read(32'h0000_3000, 3, 2'b01, 0, 1);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0; exp_err = 1'b0;
        chk("err_cleared", err_sticky, 1'b0);
        do_write(32'h0000_7000, 0, 2'b01, 0, 2'b11, 1'b1);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0; exp_err = 1'b0;

        // 6: asynchronous reset mid-burst
        send_cmd(1'b0, 32'h0000_5000, 7, 2'b01);
        @(posedge clk); #1;
        s_wvalid = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_awvalid", awvalid, 1'b0);
        chk("midrst_wvalid", wvalid, 1'b0);
        chk("midrst_s_wready", s_wready, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_bready", bready, 1'b0);
        s_wvalid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_write(32'h0000_6000, 3, 2'b01, 1, 2'b00, 1'b0);

        // randomized traffic against the model
        for (int it = 0; it < 24; it++) begin
            int idx, len, d;
            logic [1:0] b;
            logic [31:0] a;
            if (exp_err) begin
                err_clr = 1'b1;
                @(posedge clk); #1;
                err_clr = 1'b0; exp_err = 1'b0;
                chk("rand_err_clr", err_sticky, 1'b0);
            end
            idx = $urandom_range(0, 7);
            len = (idx == 7) ? $urandom_range(0, 255) : lens[idx];
            b   = 2'($urandom_range(0, 3));
            a   = $urandom;
            d   = $urandom_range(0, 2);
            if ($urandom_range(0, 1) == 1)
                do_read(a, len, b, d, ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1);
            else
                do_write(a, len, b, d,
                         ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
